// File: rtl/fp8_stream_packer_if.sv
// ---------------------------------------------------------------------------
// fp8_stream_packer_if
// Bundles the byte input stream, the packed word output stream and the
// Inf/NaN counter of the FP8 stream packer.
//   slave  : the packer side (consumes bytes, produces words)
//   master : the producer/consumer side (drives bytes, accepts words)
// Signals:
//   in_fp8/in_valid/in_last/in_ready  byte stream, valid/ready handshake
//   flush                             pulse that closes a partial word
//   out_word/out_keep/out_last        packed word, lane-valid mask, row end
//   out_valid/out_ready               word stream handshake
//   special_cnt                       saturating count of Inf/NaN bytes
// ---------------------------------------------------------------------------
interface fp8_stream_packer_if #(
  parameter int LANES = 4,
  parameter int CNT_W = 16
);
  logic [7:0]         in_fp8;
  logic               in_valid;
  logic               in_last;
  logic               in_ready;
  logic               flush;
  logic [8*LANES-1:0] out_word;
  logic [LANES-1:0]   out_keep;
  logic               out_last;
  logic               out_valid;
  logic               out_ready;
  logic [CNT_W-1:0]   special_cnt;

  modport slave (
    input  in_fp8, in_valid, in_last, flush, out_ready,
    output in_ready, out_word, out_keep, out_last, out_valid, special_cnt
  );

  modport master (
    output in_fp8, in_valid, in_last, flush, out_ready,
    input  in_ready, out_word, out_keep, out_last, out_valid, special_cnt
  );
endinterface

// File: rtl/fp8_stream_packer.sv
// ---------------------------------------------------------------------------
// fp8_stream_packer
// Packs a stream of FP8 bytes (one per cycle) into LANES-byte words for the
// result write-back bus. Lane 0 is filled first. A word is closed when its
// last lane fills, when in_last marks the end of a row, or when flush asks for
// the partial word. Unfilled lanes read as 8'h00 with their keep bit low.
// Also counts accepted Inf/NaN bytes (exponent 4'b1111), saturating.
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    fp8_stream_packer_if.slave (byte stream in, word stream out,
//          flush, special_cnt)
// ---------------------------------------------------------------------------
module fp8_stream_packer #(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fp8_stream_packer_if.slave   bus
);

  localparam int PTR_W = (LANES > 2) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    EMPTY,
    FILL,
    FLUSH_PEND
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [8*LANES-1:0] buf_q, buf_d;
  logic [8*LANES-1:0] word_q, word_d;
  logic [LANES-1:0]   keep_q, keep_d;
  logic               last_q, last_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               outFree;
  logic               inReady;
  logic               accept;
  logic               isSpecial;
  logic               lastLane;
  logic [8*LANES-1:0] mergedWord;

  // Keep mask with the lowest n lanes set.
  function automatic logic [LANES-1:0] keepMask(input int n);
    logic [LANES-1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) begin
      m[i] = (i < n);
    end
    return m;
  endfunction

  // Handshake decode. The output register is free when it is empty or being
  // drained this cycle; a pending flush owns the next free slot, so no new
  // bytes are taken while one is waiting.
  always_comb begin
    outFree   = !valid_q || bus.out_ready;
    inReady   = outFree && (state_q != FLUSH_PEND);
    accept    = bus.in_valid && inReady;
    isSpecial = (bus.in_fp8[6:3] == 4'hF);
    lastLane  = (ptr_q == PTR_W'(LANES - 1));
  end

  // The assembly buffer with the incoming byte dropped into the current lane,
  // used both when the byte just extends the buffer and when it closes a word.
  always_comb begin
    mergedWord = buf_q;
    mergedWord[{ptr_q, 3'b000} +: 8] = bus.in_fp8;
  end

  // Next-state logic for the FSM, the assembly buffer, the output register
  // and the counter. An accepted byte always wins over a flush-only close;
  // a flush arriving with a byte just closes the word after that byte.
  // With no byte accepted, a flush (or an earlier one still waiting) closes
  // the partial word as soon as the output register can take it. The output
  // register drops valid on a drain unless a new word lands on the same edge.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    buf_d   = buf_q;
    word_d  = word_q;
    keep_d  = keep_q;
    last_d  = last_q;
    valid_d = valid_q && !bus.out_ready;
    cnt_d   = cnt_q;

    if (accept) begin
      if (isSpecial && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (lastLane || bus.in_last || bus.flush) begin
        word_d  = mergedWord;
        keep_d  = keepMask(int'(ptr_q) + 1);
        last_d  = bus.in_last;
        valid_d = 1'b1;
        ptr_d   = '0;
        buf_d   = '0;
        state_d = EMPTY;
      end else begin
        buf_d   = mergedWord;
        ptr_d   = ptr_q + PTR_W'(1);
        state_d = FILL;
      end
    end else if ((state_q == FLUSH_PEND) || (bus.flush && (state_q == FILL))) begin
      if (outFree) begin
        word_d  = buf_q;
        keep_d  = keepMask(int'(ptr_q));
        last_d  = 1'b0;
        valid_d = 1'b1;
        ptr_d   = '0;
        buf_d   = '0;
        state_d = EMPTY;
      end else begin
        state_d = FLUSH_PEND;
      end
    end
  end

  // State register. Reset discards any partial word and clears the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      buf_q   <= '0;
      word_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      buf_q   <= buf_d;
      word_q  <= word_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready    = inReady;
  assign bus.out_word    = word_q;
  assign bus.out_keep    = keep_q;
  assign bus.out_last    = last_q;
  assign bus.out_valid   = valid_q;
  assign bus.special_cnt = cnt_q;

endmodule

// File: tb/tb_fp8_stream_packer.sv
// ---------------------------------------------------------------------------
// tb_fp8_stream_packer
// Drives directed scenarios and a random phase into two packers sharing the
// same stimulus: the main one (CNT_W=16) and a narrow-counter one (CNT_W=3)
// whose counter saturates quickly. Expected results come from a queue-based
// model of the packing rules.
// ---------------------------------------------------------------------------
module tb_fp8_stream_packer;
  localparam int LANES   = 4;
  localparam int CNT_W   = 16;
  localparam int SMALL_W = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp8_stream_packer_if #(.LANES(LANES), .CNT_W(CNT_W))   bus ();
  fp8_stream_packer_if #(.LANES(LANES), .CNT_W(SMALL_W)) sbus ();

  assign sbus.in_fp8    = bus.in_fp8;
  assign sbus.in_valid  = bus.in_valid;
  assign sbus.in_last   = bus.in_last;
  assign sbus.flush     = bus.flush;
  assign sbus.out_ready = bus.out_ready;

  fp8_stream_packer #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  fp8_stream_packer #(.LANES(LANES), .CNT_W(SMALL_W)) dutSmall (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sbus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: bytes waiting in the current word, a waiting
  // flush, the expected output register and the unsaturated special count.
  logic [7:0]         asmQ[$];
  bit                 pend;
  bit                 expValid;
  logic [8*LANES-1:0] expWord;
  logic [LANES-1:0]   expKeep;
  bit                 expLast;
  int                 specialTotal;

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int satCnt(input int n, input int w);
    int maxVal;
    maxVal = (1 << w) - 1;
    return (n > maxVal) ? maxVal : n;
  endfunction

  function automatic logic [8*LANES-1:0] packQueue();
    logic [8*LANES-1:0] w;
    w = '0;
    foreach (asmQ[i]) w[8*i +: 8] = asmQ[i];
    return w;
  endfunction

  task automatic modelReset();
    asmQ.delete();
    pend         = 1'b0;
    expValid     = 1'b0;
    expWord      = '0;
    expKeep      = '0;
    expLast      = 1'b0;
    specialTotal = 0;
  endtask

  task automatic checkReset(input string tag);
    checkValue({tag, "_valid"}, 64'(bus.out_valid), 64'(0));
    checkValue({tag, "_word"},  64'(bus.out_word), 64'(0));
    checkValue({tag, "_keep"},  64'(bus.out_keep), 64'(0));
    checkValue({tag, "_last"},  64'(bus.out_last), 64'(0));
    checkValue({tag, "_cnt"},   64'(bus.special_cnt), 64'(0));
    checkValue({tag, "_scnt"},  64'(sbus.special_cnt), 64'(0));
  endtask

  task automatic checkOutput();
    checkValue("out_valid", 64'(bus.out_valid), 64'(expValid));
    if (expValid) begin
      checkValue("out_word", 64'(bus.out_word), 64'(expWord));
      checkValue("out_keep", 64'(bus.out_keep), 64'(expKeep));
      checkValue("out_last", 64'(bus.out_last), 64'(expLast));
    end
    checkValue("special_cnt", 64'(bus.special_cnt), 64'(satCnt(specialTotal, CNT_W)));
    checkValue("small_cnt", 64'(sbus.special_cnt), 64'(satCnt(specialTotal, SMALL_W)));
  endtask

  // One clock cycle: drive inputs after the falling edge, check in_ready,
  // advance the model over the rising edge, then check the outputs.
  task automatic applyStimulus(input logic [7:0] b, input bit v, input bit l,
                               input bit f, input bit r, output bit acc);
    bit expReady;
    bit free;
    bit closeW;
    @(negedge clk);
    bus.in_fp8    = b;
    bus.in_valid  = v;
    bus.in_last   = l;
    bus.flush     = f;
    bus.out_ready = r;
    #1;
    expReady = (!expValid || r) && !pend;
    checkValue("in_ready", 64'(bus.in_ready), 64'(expReady));
    checkValue("small_in_ready", 64'(sbus.in_ready), 64'(expReady));

    acc    = v && expReady;
    free   = !expValid || r;
    closeW = 1'b0;
    if (acc) begin
      if (b[6:3] == 4'hF) specialTotal++;
      asmQ.push_back(b);
      if ((asmQ.size() == LANES) || l || f) begin
        expWord = packQueue();
        expKeep = LANES'((1 << asmQ.size()) - 1);
        expLast = l;
        closeW  = 1'b1;
      end
    end else if ((f || pend) && (asmQ.size() > 0)) begin
      if (free) begin
        expWord = packQueue();
        expKeep = LANES'((1 << asmQ.size()) - 1);
        expLast = 1'b0;
        closeW  = 1'b1;
        pend    = 1'b0;
      end else begin
        pend = 1'b1;
      end
    end
    if (closeW) begin
      expValid = 1'b1;
      asmQ.delete();
    end else if (expValid && r) begin
      expValid = 1'b0;
    end

    @(posedge clk);
    #1;
    checkOutput();
  endtask

  function automatic logic [7:0] randByte();
    logic [7:0] b;
    if ($urandom_range(0, 3) == 0) b = {1'($urandom), 4'hF, 3'($urandom)};
    else b = 8'($urandom);
    return b;
  endfunction

  initial begin
    bit acc;
    int idx;
    int cyc;
    int relCycles;
    logic [7:0] seq8 [8];

    bus.in_fp8    = 8'h00;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    modelReset();

    // Reset state.
    #12;
    checkReset("rst0");
    @(negedge clk);
    rst_n = 1'b1;

    // Four full lanes, little-endian.
    applyStimulus(8'h11, 1, 0, 0, 1, acc);
    applyStimulus(8'h22, 1, 0, 0, 1, acc);
    applyStimulus(8'h33, 1, 0, 0, 1, acc);
    applyStimulus(8'h44, 1, 0, 0, 1, acc);
    checkValue("t1_word", 64'(bus.out_word), 64'h44332211);
    checkValue("t1_keep", 64'(bus.out_keep), 64'hF);
    checkValue("t1_last", 64'(bus.out_last), 64'h0);
    checkValue("t1_valid", 64'(bus.out_valid), 64'h1);
    applyStimulus(8'h00, 0, 0, 0, 1, acc);
    checkValue("t1_valid_drop", 64'(bus.out_valid), 64'h0);

    // Partial word closed by in_last.
    applyStimulus(8'hAA, 1, 0, 0, 1, acc);
    applyStimulus(8'hBB, 1, 1, 0, 1, acc);
    checkValue("t2_word", 64'(bus.out_word), 64'h0000BBAA);
    checkValue("t2_keep", 64'(bus.out_keep), 64'h3);
    checkValue("t2_last", 64'(bus.out_last), 64'h1);
    applyStimulus(8'h00, 0, 0, 0, 1, acc);

    // Backpressure: eight bytes offered, out_ready low for six cycles.
    for (int i = 0; i < 8; i++) seq8[i] = 8'(i + 1);
    idx = 0;
    for (cyc = 0; cyc < 6; cyc++) begin
      applyStimulus(seq8[idx], 1, 0, 0, 0, acc);
      if (acc) idx++;
    end
    checkValue("t3_accepted", 64'(idx), 64'd4);
    checkValue("t3_held_word", 64'(bus.out_word), 64'h04030201);
    relCycles = 0;
    while ((idx < 8) && (relCycles < 16)) begin
      applyStimulus(seq8[idx], 1, 0, 0, 1, acc);
      if (acc) idx++;
      relCycles++;
    end
    checkValue("t3_no_bubble", 64'(relCycles), 64'd4);
    checkValue("t3_word2", 64'(bus.out_word), 64'h08070605);
    applyStimulus(8'h00, 0, 0, 0, 1, acc);

    // Flush of a one-byte partial word, then held while out_ready is low.
    applyStimulus(8'h5C, 1, 0, 0, 1, acc);
    applyStimulus(8'h00, 0, 0, 1, 0, acc);
    applyStimulus(8'h00, 0, 0, 0, 0, acc);
    applyStimulus(8'h00, 0, 0, 0, 0, acc);
    checkValue("t4_word", 64'(bus.out_word), 64'h0000005C);
    checkValue("t4_keep", 64'(bus.out_keep), 64'h1);
    checkValue("t4_last", 64'(bus.out_last), 64'h0);
    applyStimulus(8'h00, 0, 0, 0, 1, acc);
    // Flush with nothing buffered emits no word.
    applyStimulus(8'h00, 0, 0, 1, 1, acc);
    checkValue("t4_empty_flush", 64'(bus.out_valid), 64'h0);

    // Inf/NaN counting, then saturate the narrow counter.
    applyStimulus(8'h78, 1, 0, 0, 1, acc);
    applyStimulus(8'hF9, 1, 0, 0, 1, acc);
    applyStimulus(8'h7F, 1, 0, 0, 1, acc);
    applyStimulus(8'h00, 1, 1, 0, 1, acc);
    checkValue("t5_cnt", 64'(bus.special_cnt), 64'd3);
    for (int i = 0; i < 8; i++) applyStimulus(8'hF8, 1, 0, 0, 1, acc);
    checkValue("t5_cnt_main", 64'(bus.special_cnt), 64'd11);
    checkValue("t5_cnt_sat", 64'(sbus.special_cnt), 64'd7);
    applyStimulus(8'h00, 0, 0, 0, 1, acc);

    // Asynchronous reset with a partial word buffered.
    applyStimulus(8'hC1, 1, 0, 0, 1, acc);
    applyStimulus(8'hC2, 1, 0, 0, 1, acc);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkReset("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'hA1, 1, 0, 0, 1, acc);
    applyStimulus(8'hA2, 1, 0, 0, 1, acc);
    applyStimulus(8'hA3, 1, 0, 0, 1, acc);
    applyStimulus(8'hA4, 1, 0, 0, 1, acc);
    checkValue("t6_word", 64'(bus.out_word), 64'hA4A3A2A1);
    checkValue("t6_keep", 64'(bus.out_keep), 64'hF);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(randByte(),
                    $urandom_range(0, 3) != 0,
                    $urandom_range(0, 6) == 0,
                    $urandom_range(0, 9) == 0,
                    $urandom_range(0, 4) < 3,
                    acc);
    end
    for (int i = 0; i < 3; i++) applyStimulus(8'h00, 0, 0, 1, 1, acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
